// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: N-channel PWM generator with a shared prescaler and base
// counter, double-buffered duties applied at the period wrap, optional
// per-channel phase stagger and optional active-low outputs.
module pwm_multi_channel #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PRE_W    = 8,
    parameter bit          STAGGER  = 1'b0,
    parameter bit          ACT_LOW  = 1'b0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             en,
    input  logic [PRE_W-1:0]                 prescale,
    input  logic [CHANNELS*(WIDTH+1)-1:0]    duty_in,
    input  logic                             update,
    output logic                             update_pend,
    output logic                             period_start,
    output logic [CHANNELS-1:0]              pwm_out
);

    // Phase step between adjacent channels when staggering (truncated).
    localparam int unsigned SPAN = (2 ** WIDTH) / CHANNELS;

    logic [PRE_W-1:0]                pre_cnt;
    logic [WIDTH-1:0]                base_cnt;
    logic [CHANNELS*(WIDTH+1)-1:0]   shadow;
    logic [CHANNELS*(WIDTH+1)-1:0]   duty_act;
    logic [WIDTH-1:0]                cnt_ch [CHANNELS];
    logic [CHANNELS-1:0]             raw;
    logic                            tick;
    logic                            wrap;

    // Tick generation; '>=' lets a shrinking prescale fire at once instead of
    // running pre_cnt all the way round.
    always_comb begin
        tick = en && (pre_cnt >= prescale);
        wrap = tick && (base_cnt == '1);
    end

    // Prescaler and base counter; both freeze while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt  <= '0;
            base_cnt <= '0;
        end else if (tick) begin
            pre_cnt  <= '0;
            base_cnt <= base_cnt + WIDTH'(1);
        end else if (en) begin
            pre_cnt  <= pre_cnt + PRE_W'(1);
        end
    end

    // Duty double buffer: capture on update, apply on the period wrap.
    // A capture on the wrap cycle keeps the pend flag for the next period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow      <= '0;
            duty_act    <= '0;
            update_pend <= 1'b0;
        end else begin
            if (wrap) begin
                duty_act <= shadow;
            end
            if (update) begin
                shadow      <= duty_in;
                update_pend <= 1'b1;
            end else if (wrap) begin
                update_pend <= 1'b0;
            end
        end
    end

    // Per-channel count and compare; duty >= 2^WIDTH is always on.
    always_comb begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (STAGGER) begin
                cnt_ch[i] = base_cnt + WIDTH'(i * SPAN);
            end else begin
                cnt_ch[i] = base_cnt;
            end
            raw[i] = ({1'b0, cnt_ch[i]} < duty_act[i*(WIDTH+1) +: WIDTH+1]);
        end
    end

    // Registered pins and period marker.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out      <= {CHANNELS{ACT_LOW}};
            period_start <= 1'b0;
        end else begin
            pwm_out      <= ({CHANNELS{en}} & raw) ^ {CHANNELS{ACT_LOW}};
            period_start <= wrap;
        end
    end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Bench for pwm_multi_channel: two instances (in-phase active-high and
// staggered active-low) share stimulus and are checked every cycle against
// an arithmetic reference model, plus table vectors and corner sequences.
module tb_pwm_multi_channel;

    localparam int W  = 4;
    localparam int CH = 4;
    localparam int PW = 8;
    localparam int PERIOD = 16;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   en;
    logic                   update;
    logic [PW-1:0]          prescale;
    logic [CH*(W+1)-1:0]    duty_in;
    logic                   pend_a, ps_a, pend_b, ps_b;
    logic [CH-1:0]          pwm_a, pwm_b;

    int d_val [CH];
    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int          m_pre, m_base;
    int          m_shadow [CH];
    int          m_act    [CH];
    bit          m_pend, m_ps;
    bit [CH-1:0] m_out_a, m_out_b;

    pwm_multi_channel #(.CHANNELS(CH), .WIDTH(W), .PRE_W(PW), .STAGGER(1'b0), .ACT_LOW(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .prescale(prescale), .duty_in(duty_in),
        .update(update), .update_pend(pend_a), .period_start(ps_a), .pwm_out(pwm_a)
    );

    pwm_multi_channel #(.CHANNELS(CH), .WIDTH(W), .PRE_W(PW), .STAGGER(1'b1), .ACT_LOW(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .prescale(prescale), .duty_in(duty_in),
        .update(update), .update_pend(pend_b), .period_start(ps_b), .pwm_out(pwm_b)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int duty;
        int exp_high;
    } vec_t;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endfunction

    function automatic void timeout(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: got timeout expected event at %0t", nm, $time);
    endfunction

    task automatic drive_duty();
        for (int c = 0; c < CH; c++) duty_in[c*(W+1) +: W+1] = 5'(d_val[c]);
    endtask

    task automatic model_reset();
        m_pre = 0; m_base = 0; m_pend = 0; m_ps = 0;
        for (int c = 0; c < CH; c++) begin m_shadow[c] = 0; m_act[c] = 0; end
        m_out_a = '0;
        m_out_b = '1;
    endtask

    // One clock of behaviour: outputs from the pre-edge state, then advance.
    task automatic model_step();
        bit tk, wr;
        if (!rst_n) begin model_reset(); return; end
        tk = en && (m_pre >= int'(prescale));
        for (int c = 0; c < CH; c++) begin
            m_out_a[c] = en && (m_base < m_act[c]);
            m_out_b[c] = !(en && (((m_base + c * (PERIOD / CH)) % PERIOD) < m_act[c]));
        end
        wr   = tk && (m_base == PERIOD - 1);
        m_ps = wr;
        if (tk) begin
            m_pre  = 0;
            m_base = (m_base + 1) % PERIOD;
        end else if (en) begin
            m_pre++;
        end
        if (wr) for (int c = 0; c < CH; c++) m_act[c] = m_shadow[c];
        if (update) begin
            for (int c = 0; c < CH; c++) m_shadow[c] = int'(duty_in[c*(W+1) +: W+1]);
            m_pend = 1;
        end else if (wr) begin
            m_pend = 0;
        end
    endtask

    task automatic check_all();
        chk("pwm_a", 32'(pwm_a), 32'(m_out_a));
        chk("pwm_b", 32'(pwm_b), 32'(m_out_b));
        chk("pend_a", 32'(pend_a), 32'(m_pend));
        chk("pend_b", 32'(pend_b), 32'(m_pend));
        chk("pstart_a", 32'(ps_a), 32'(m_ps));
        chk("pstart_b", 32'(ps_b), 32'(m_ps));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic strobe_update();
        drive_duty();
        update = 1'b1;
        cycle();
        update = 1'b0;
    endtask

    // Run until the model reports a period start (i.e. an apply happened).
    task automatic wait_apply(input string nm);
        int k = 0;
        do begin cycle(); k++; end while (!m_ps && k < 300);
        if (!m_ps) timeout(nm);
    endtask

    task automatic measure_period(input int expect_len, input string nm);
        int k = 0;
        while (ps_a !== 1'b1 && k < 300) begin cycle(); k++; end
        if (ps_a !== 1'b1) begin timeout(nm); return; end
        k = 0;
        do begin cycle(); k++; end while (ps_a !== 1'b1 && k < 300);
        chk(nm, 32'(k), 32'(expect_len));
    endtask

    initial begin
        vec_t tv [6];
        int   hi, k;
        int   rise [CH];
        logic [CH-1:0] prev, cur;

        tv[0] = '{5, 5};   tv[1] = '{0, 0};   tv[2] = '{16, 16};
        tv[3] = '{31, 16}; tv[4] = '{12, 12}; tv[5] = '{1, 1};

        rst_n = 1'b0; en = 1'b0; update = 1'b0; prescale = '0;
        for (int c = 0; c < CH; c++) d_val[c] = 0;
        drive_duty();
        model_reset();
        cycle();
        cycle();
        rst_n = 1'b1;
        en    = 1'b1;

        // duty table: high count over three periods after the apply
        for (int i = 0; i < 6; i++) begin
            d_val[0] = tv[i].duty;
            d_val[1] = i + 2;
            strobe_update();
            wait_apply("apply_tbl");
            hi = 0;
            for (int j = 0; j < 3 * PERIOD; j++) begin
                cycle();
                hi += int'(pwm_a[0]);
            end
            chk("tbl_high", 32'(hi), 32'(3 * tv[i].exp_high));
        end
        measure_period(PERIOD, "period_p0");

        // mid-period update: current period keeps old duty, next shows new
        d_val[0] = 3;
        strobe_update();
        wait_apply("apply_3");
        k = 0;
        while (m_base != 7 && k < 40) begin cycle(); k++; end
        if (m_base != 7) timeout("reach_cnt7");
        d_val[0] = 12;
        strobe_update();
        hi = 0;
        k = 0;
        while (!m_ps && k < 40) begin
            cycle();
            hi += int'(pwm_a[0]);
            k++;
        end
        if (!m_ps) timeout("apply_12");
        chk("keep_old_duty", 32'(hi), 32'(0));
        hi = 0;
        for (int j = 0; j < PERIOD; j++) begin cycle(); hi += int'(pwm_a[0]); end
        chk("new_duty_high", 32'(hi), 32'(12));

        // prescaler length and live shrink
        prescale = 8'd2;
        measure_period(3 * PERIOD, "period_p2");
        prescale = 8'd9;
        k = 0;
        while (m_pre != 5 && k < 40) begin cycle(); k++; end
        if (m_pre != 5) timeout("reach_pre5");
        prescale = 8'd1;
        cycle();
        measure_period(2 * PERIOD, "period_p1");
        prescale = 8'd0;

        // stagger: rising edge positions within a period
        for (int c = 0; c < CH; c++) d_val[c] = 4;
        strobe_update();
        wait_apply("apply_stag");
        wait_apply("apply_stag2");
        prev = ~pwm_b;
        for (int c = 0; c < CH; c++) rise[c] = -1;
        for (int j = 1; j <= PERIOD; j++) begin
            cycle();
            cur = ~pwm_b;
            for (int c = 0; c < CH; c++)
                if (cur[c] && !prev[c] && rise[c] < 0) rise[c] = j;
            prev = cur;
        end
        for (int c = 0; c < CH; c++)
            chk("stagger_rise", 32'(rise[c]), 32'(1 + ((PERIOD - c * (PERIOD / CH)) % PERIOD)));

        // async reset mid-period with an update pending
        d_val[0] = 9;
        strobe_update();
        cycle();
        cycle();
        chk("pend_before_rst", 32'(pend_a), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        cycle();
        rst_n = 1'b1;

        // en low: hold, outputs inactive, update still captures
        d_val[0] = 10;
        strobe_update();
        for (int j = 0; j < 5; j++) cycle();
        en = 1'b0;
        for (int j = 0; j < 20; j++) begin
            if (j == 6) begin d_val[1] = 7; strobe_update(); end
            else cycle();
        end
        en = 1'b1;
        for (int j = 0; j < 40; j++) cycle();

        // random traffic against the model
        for (int j = 0; j < 1500; j++) begin
            for (int c = 0; c < CH; c++) d_val[c] = $urandom_range(0, 20);
            drive_duty();
            update = ($urandom_range(0, 7) == 0);
            en     = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 49) == 0) prescale = 8'($urandom_range(0, 3));
            cycle();
        end
        update = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
